// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode/operand stage and the execute stage.
//   XLEN     : operand / PC width
//   CTRL_W   : width of the opaque decoded-control bundle
//   REG_W    : register-index width
//   REG_ZERO : index of the hard-wired zero register
//   id_ex_t  : contents of the ID/EX pipeline register
//   reg_match: true when a source index is nonzero and equals a destination
package id_operand_stage_pkg;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;
   localparam int REG_W  = 5;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      logic [XLEN-1:0]   imm;
      logic [REG_W-1:0]  rd;
      logic              we;
      logic              is_load;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_t;

   // x0 never matches anything: it is neither forwarded nor a hazard source.
   function automatic logic reg_match(input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rd);
      return (rs != REG_ZERO) && (rs == rd);
   endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Upstream decode handshake plus downstream ID/EX handshake.
//   slave  : the operand stage (consumes in_*, produces out_*)
//   master : the surrounding pipeline / testbench
interface id_operand_stage_if;
   import id_operand_stage_pkg::*;

   // decode side
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc;
   logic [REG_W-1:0]  in_rs1;
   logic [REG_W-1:0]  in_rs2;
   logic              in_use_rs1;
   logic              in_use_rs2;
   logic [REG_W-1:0]  in_rd;
   logic              in_we;
   logic              in_is_load;
   logic [XLEN-1:0]   in_imm;
   logic [CTRL_W-1:0] in_ctrl;

   // execute side
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_op1;
   logic [XLEN-1:0]   out_op2;
   logic [XLEN-1:0]   out_imm;
   logic [REG_W-1:0]  out_rd;
   logic              out_we;
   logic              out_is_load;
   logic [CTRL_W-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_rd, in_we, in_is_load, in_imm, in_ctrl, out_ready,
      output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
             out_rd, out_we, out_is_load, out_ctrl
   );

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2,
             in_rd, in_we, in_is_load, in_imm, in_ctrl, out_ready,
      input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
             out_rd, out_we, out_is_load, out_ctrl
   );

endinterface

// File: rtl/id_operand_stage_operand_bypass.sv
// Combinational operand mux for one source register.
//   rs       : source index
//   rf_data  : register-file read data for rs
//   mem_*    : MEM-stage producer (loads are not forwarded, data not ready)
//   wb_*     : WB-stage producer (same write that lands in the RF next edge)
//   operand  : selected value, youngest producer first
module id_operand_stage_operand_bypass
   import id_operand_stage_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic [XLEN-1:0]  rf_data,
   input  logic             mem_valid,
   input  logic             mem_we,
   input  logic             mem_is_load,
   input  logic [REG_W-1:0] mem_wa,
   input  logic [XLEN-1:0]  mem_wd,
   input  logic             wb_we,
   input  logic [REG_W-1:0] wb_wa,
   input  logic [XLEN-1:0]  wb_wd,
   output logic [XLEN-1:0]  operand
);

   always_comb begin
      if (rs == REG_ZERO) begin
         operand = '0;
      end else if (mem_valid && mem_we && !mem_is_load && mem_wa == rs) begin
         operand = mem_wd;
      end else if (wb_we && wb_wa == rs) begin
         operand = wb_wd;
      end else begin
         operand = rf_data;
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: reads the RF, bypasses MEM/WB results,
// interlocks on EX producers and MEM loads, and fills the ID/EX register.
//   clk, rstn            : clock, asynchronous active-low reset
//   bus (slave)          : decode handshake in, ID/EX handshake out
//   rf_ra0/rf_ra1        : RF read addresses (straight from rs1/rs2)
//   rf_rd0/rf_rd1        : RF read data
//   mem_*                : MEM-stage instruction info
//   wb_*                 : WB write port (also feeding the RF)
//   flush                : drop the ID/EX instruction and the presented one
//   stall_cnt            : saturating count of cycles the input was stalled
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   id_operand_stage_if.slave bus,
   output logic [REG_W-1:0]  rf_ra0,
   output logic [REG_W-1:0]  rf_ra1,
   input  logic [XLEN-1:0]   rf_rd0,
   input  logic [XLEN-1:0]   rf_rd1,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [REG_W-1:0]  mem_wa,
   input  logic [XLEN-1:0]   mem_wd,
   input  logic              wb_we,
   input  logic [REG_W-1:0]  wb_wa,
   input  logic [XLEN-1:0]   wb_wd,
   input  logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   id_ex_t           ex_reg;
   logic             valid_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic [REG_W-1:0] rs_sel  [2];
   logic [XLEN-1:0]  rf_sel  [2];
   logic [XLEN-1:0]  op_sel  [2];
   logic             use_sel [2];
   logic [1:0]       src_hazard;
   logic             hazard;
   logic             hold;
   logic             stall_event;

   assign rf_ra0 = bus.in_rs1;
   assign rf_ra1 = bus.in_rs2;

   assign rs_sel[0]  = bus.in_rs1;
   assign rs_sel[1]  = bus.in_rs2;
   assign rf_sel[0]  = rf_rd0;
   assign rf_sel[1]  = rf_rd1;
   assign use_sel[0] = bus.in_use_rs1;
   assign use_sel[1] = bus.in_use_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         id_operand_stage_operand_bypass u_bypass (
            .rs          (rs_sel[gi]),
            .rf_data     (rf_sel[gi]),
            .mem_valid   (mem_valid),
            .mem_we      (mem_we),
            .mem_is_load (mem_is_load),
            .mem_wa      (mem_wa),
            .mem_wd      (mem_wd),
            .wb_we       (wb_we),
            .wb_wa       (wb_wa),
            .wb_wd       (wb_wd),
            .operand     (op_sel[gi])
         );

         // EX result is not available yet, and a MEM load has no data yet:
         // neither can be bypassed, so the instruction must wait.
         assign src_hazard[gi] = use_sel[gi] &&
            ((valid_reg && ex_reg.we && reg_match(rs_sel[gi], ex_reg.rd)) ||
             (mem_valid && mem_we && mem_is_load && reg_match(rs_sel[gi], mem_wa)));
      end
   endgenerate

   assign hazard      = bus.in_valid && (|src_hazard);
   assign hold        = valid_reg && !bus.out_ready;
   assign bus.in_ready = flush || (!hold && !hazard);
   assign stall_event = bus.in_valid && !bus.in_ready && !flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_reg     <= 1'b0;
         ex_reg        <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (flush) begin
            valid_reg <= 1'b0;
         end else if (hold) begin
            // Operands captured at acceptance remain correct; do not re-read.
            valid_reg <= valid_reg;
         end else if (hazard) begin
            valid_reg <= 1'b0;
         end else if (bus.in_valid) begin
            valid_reg <= 1'b1;
            ex_reg    <= '{pc:      bus.in_pc,
                           op1:     op_sel[0],
                           op2:     op_sel[1],
                           imm:     bus.in_imm,
                           rd:      bus.in_rd,
                           we:      bus.in_we,
                           is_load: bus.in_is_load,
                           ctrl:    bus.in_ctrl};
         end else begin
            valid_reg <= 1'b0;
         end

         if (stall_event && stall_cnt_reg != '1) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign bus.out_valid   = valid_reg;
   assign bus.out_pc      = ex_reg.pc;
   assign bus.out_op1     = ex_reg.op1;
   assign bus.out_op2     = ex_reg.op2;
   assign bus.out_imm     = ex_reg.imm;
   assign bus.out_rd      = ex_reg.rd;
   assign bus.out_we      = ex_reg.we;
   assign bus.out_is_load = ex_reg.is_load;
   assign bus.out_ctrl    = ex_reg.ctrl;
   assign stall_cnt       = stall_cnt_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed testbench for id_operand_stage with a scoreboard of expected
// ID/EX contents: pushed on acceptance, popped when EX consumes.
module tb_id_operand_stage;
   import id_operand_stage_pkg::*;

   logic             clk = 1'b0;
   logic             rstn;
   logic [REG_W-1:0] rf_ra0, rf_ra1;
   logic [XLEN-1:0]  rf_rd0, rf_rd1;
   logic             mem_valid, mem_we, mem_is_load;
   logic [REG_W-1:0] mem_wa;
   logic [XLEN-1:0]  mem_wd;
   logic             wb_we;
   logic [REG_W-1:0] wb_wa;
   logic [XLEN-1:0]  wb_wd;
   logic             flush;
   logic [31:0]      stall_cnt;

   logic [XLEN-1:0]  regs [32];

   id_operand_stage_if bus ();

   id_operand_stage #(.CNT_W(32)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus),
      .rf_ra0      (rf_ra0),
      .rf_ra1      (rf_ra1),
      .rf_rd0      (rf_rd0),
      .rf_rd1      (rf_rd1),
      .mem_valid   (mem_valid),
      .mem_we      (mem_we),
      .mem_is_load (mem_is_load),
      .mem_wa      (mem_wa),
      .mem_wd      (mem_wd),
      .wb_we       (wb_we),
      .wb_wa       (wb_wa),
      .wb_wd       (wb_wd),
      .flush       (flush),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   assign rf_rd0 = regs[rf_ra0];
   assign rf_rd1 = regs[rf_ra1];

   int     n_cmp = 0;
   int     n_mis = 0;
   id_ex_t exp_q [$];
   id_ex_t exp_next;
   logic   last_in_ready;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [XLEN-1:0] pc, input logic [REG_W-1:0] rs1,
                        input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rd,
                        input logic we, input logic ld,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
      bus.in_valid   = 1'b1;
      bus.in_pc      = pc;
      bus.in_rs1     = rs1;
      bus.in_rs2     = rs2;
      bus.in_use_rs1 = 1'b1;
      bus.in_use_rs2 = 1'b1;
      bus.in_rd      = rd;
      bus.in_we      = we;
      bus.in_is_load = ld;
      bus.in_imm     = pc ^ 32'h5A5A_0000;
      bus.in_ctrl    = pc[15:0] ^ 16'hC3C3;
      exp_next = '{pc: pc, op1: e1, op2: e2, imm: pc ^ 32'h5A5A_0000, rd: rd,
                   we: we, is_load: ld, ctrl: pc[15:0] ^ 16'hC3C3};
   endtask

   // One cycle: sample just after the negedge drive, then advance to next negedge.
   task automatic tick();
      id_ex_t obs;
      id_ex_t e;
      #1;
      last_in_ready = bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
         chk("txn_expected", 160'(exp_q.size() != 0), 160'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            obs = '{pc: bus.out_pc, op1: bus.out_op1, op2: bus.out_op2, imm: bus.out_imm,
                    rd: bus.out_rd, we: bus.out_we, is_load: bus.out_is_load,
                    ctrl: bus.out_ctrl};
            $display("txn pc=%h op1=%h op2=%h rd=%0d", obs.pc, obs.op1, obs.op2, obs.rd);
            chk("txn_fields", 160'(obs), 160'(e));
         end
      end
      if (bus.in_valid && bus.in_ready && !flush) exp_q.push_back(exp_next);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      rstn = 1'b0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
      bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0; bus.in_rd = '0; bus.in_we = 1'b0;
      bus.in_is_load = 1'b0; bus.in_imm = '0; bus.in_ctrl = '0; bus.out_ready = 1'b1;
      mem_valid = 1'b0; mem_we = 1'b0; mem_is_load = 1'b0; mem_wa = '0; mem_wd = '0;
      wb_we = 1'b0; wb_wa = '0; wb_wd = '0; flush = 1'b0;

      // reset state
      #2;
      chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
      chk("rst_stall_cnt", 160'(stall_cnt), 160'(0));
      chk("rst_out_op1", 160'(bus.out_op1), 160'(0));
      @(negedge clk);
      rstn = 1'b1;

      // plain RF read, x0 source reads as zero
      regs[5] = 32'h1234;
      drive(32'h100, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 32'h1234, 32'h0);
      tick();
      chk("first_out_valid", 160'(bus.out_valid), 160'(1));

      // WB bypass over a stale RF value
      regs[7] = 32'h0;
      wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'hAAAA;
      drive(32'h104, 5'd7, 5'd5, 5'd2, 1'b0, 1'b0, 32'hAAAA, 32'h1234);
      tick();

      // MEM (non-load) wins over WB
      mem_valid = 1'b1; mem_we = 1'b1; mem_is_load = 1'b0; mem_wa = 5'd7; mem_wd = 32'hBBBB;
      drive(32'h108, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 32'hBBBB, 32'h0);
      tick();
      mem_valid = 1'b0; wb_we = 1'b0;

      // EX producer rd=3: one bubble, then MEM forward
      drive(32'h10C, 5'd0, 5'd3, 5'd6, 1'b1, 1'b0, 32'h0, 32'h3333);
      tick();
      chk("ex_haz_in_ready", 160'(last_in_ready), 160'(0));
      chk("ex_haz_bubble", 160'(bus.out_valid), 160'(0));
      chk("ex_haz_stall_cnt", 160'(stall_cnt), 160'(1));
      mem_valid = 1'b1; mem_we = 1'b1; mem_is_load = 1'b0; mem_wa = 5'd3; mem_wd = 32'h3333;
      tick();
      chk("ex_haz_accept", 160'(last_in_ready), 160'(1));
      chk("ex_haz_stall_hold", 160'(stall_cnt), 160'(1));

      // load in MEM: one stall, then WB bypass of load data
      mem_valid = 1'b1; mem_we = 1'b1; mem_is_load = 1'b1; mem_wa = 5'd9; mem_wd = 32'h5555;
      drive(32'h110, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1234);
      tick();
      chk("ld_haz_in_ready", 160'(last_in_ready), 160'(0));
      chk("ld_haz_bubble", 160'(bus.out_valid), 160'(0));
      chk("ld_haz_stall_cnt", 160'(stall_cnt), 160'(2));
      mem_valid = 1'b0; mem_is_load = 1'b0;
      wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'hDEADBEEF;
      tick();
      chk("ld_accept", 160'(last_in_ready), 160'(1));
      wb_we = 1'b0;

      // hold for 3 cycles (next instruction also hazards on rd=10: hold wins)
      bus.out_ready = 1'b0;
      drive(32'h114, 5'd5, 5'd10, 5'd11, 1'b1, 1'b0, 32'h1234, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_in_ready", 160'(last_in_ready), 160'(0));
         chk("hold_out_valid", 160'(bus.out_valid), 160'(1));
         chk("hold_out_pc", 160'(bus.out_pc), 160'(32'h110));
         chk("hold_out_op1", 160'(bus.out_op1), 160'(32'hDEADBEEF));
      end
      chk("hold_stall_cnt", 160'(stall_cnt), 160'(5));

      // flush during hold kills the held instruction and the presented one
      flush = 1'b1;
      void'(exp_q.pop_front());
      tick();
      chk("flush_in_ready", 160'(last_in_ready), 160'(1));
      chk("flush_out_valid", 160'(bus.out_valid), 160'(0));
      chk("flush_stall_cnt", 160'(stall_cnt), 160'(5));
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      tick();

      // asynchronous reset in the middle of a hold
      drive(32'h118, 5'd5, 5'd0, 5'd12, 1'b1, 1'b0, 32'h1234, 32'h0);
      tick();
      bus.out_ready = 1'b0;
      drive(32'h11C, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      chk("pre_rst_stall_cnt", 160'(stall_cnt), 160'(6));
      chk("pre_rst_out_valid", 160'(bus.out_valid), 160'(1));
      #2;
      rstn = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      chk("async_rst_out_valid", 160'(bus.out_valid), 160'(0));
      chk("async_rst_stall_cnt", 160'(stall_cnt), 160'(0));
      chk("async_rst_out_pc", 160'(bus.out_pc), 160'(0));
      exp_q.delete();
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", 160'(bus.out_valid), 160'(0));

      // back-to-back burst, no hazards: one per cycle
      for (int i = 0; i < 4; i++) regs[20 + i] = 32'hC000_0000 + 32'(i * 17);
      for (int i = 0; i < 4; i++) begin
         drive(32'h200 + 32'(4 * i), 5'(20 + i), 5'(23 - i), 5'd0, 1'b0, 1'(i % 2),
               32'hC000_0000 + 32'(i * 17), 32'hC000_0000 + 32'((3 - i) * 17));
         tick();
         chk("burst_in_ready", 160'(last_in_ready), 160'(1));
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4 && exp_q.size() != 0; k++) tick();
      chk("queue_drained", 160'(exp_q.size()), 160'(0));
      chk("burst_stall_cnt", 160'(stall_cnt), 160'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-to-execute pipeline stage directly upstream of the execute stage and the consumer of the register file read ports.
- Drives the two RF read addresses and captures the operands into the ID/EX register.
- Bypasses results from the MEM and WB stages, because an RF write only lands at the next clk edge.
- Interlocks on hazards that cannot be bypassed. Downstream handshake is valid/ready; it also supports flush and keeps a stall-cycle counter.

Parameters:
- XLEN, 32, data width of operands and PC.
- CTRL_W, 16, width of the opaque decoded-control bundle passed through.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2  in  5  source register indices
- in_use_rs1, in_use_rs2  in  1  source actually read
- in_rd  in  5  destination index
- in_we  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_imm  in  XLEN  immediate
- in_ctrl  in  CTRL_W  decoded control
- rf_ra0, rf_ra1  out  5  RF read addresses (combinational = in_rs1/in_rs2)
- rf_rd0, rf_rd1  in  XLEN  RF read data (combinational)
- mem_valid, mem_we, mem_is_load  in  1  MEM-stage instruction info
- mem_wa  in  5  MEM-stage destination index
- mem_wd  in  XLEN  MEM-stage ALU result
- wb_we  in  1  WB write enable (same signal feeding RF)
- wb_wa  in  5  WB write address
- wb_wd  in  XLEN  WB write data
- flush  in  1  kill the instruction in this stage and the one presented
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute stage accepts
- out_pc, out_op1, out_op2, out_imm  out  XLEN  registered outputs
- out_rd  out  5  registered destination index
- out_we, out_is_load  out  1  registered flags
- out_ctrl  out  CTRL_W  registered control
- stall_cnt  out  CNT_W  cycles in which in_valid=1 and in_ready=0 with no flush

Behaviour:
- Reset, asynchronous while rstn=0: every out_* = 0, out_valid=0, stall_cnt=0.
- Operand selection is combinational and done per source; op1 (rs1) and op2 (rs2) are handled identically:
  - If rs==0, the operand is 0; never forward x0.
  - Else if mem_valid & mem_we & ~mem_is_load & mem_wa==rs, the operand is mem_wd.
  - Else if wb_we & wb_wa==rs, the operand is wb_wd.
  - Else the operand is rf_rd0 (op1) or rf_rd1 (op2).
- Priority: MEM over WB over RF, so the youngest value wins.
- Hazard (combinational) is true when in_valid and any used, nonzero source matches either:
  - the EX instruction: out_valid & out_we & out_rd==rs; or
  - a MEM load: mem_valid & mem_we & mem_is_load & mem_wa==rs.
- hold = out_valid & ~out_ready.
- in_ready = ~hold & ~hazard, or 1 while flush=1 (the presented instruction is discarded).
- Register update at each clk edge, first matching rule wins:
  - flush: out_valid<=0; other outputs are don't-care but hold their values.
  - hold: all outputs unchanged; the instruction is not re-evaluated.
  - hazard: out_valid<=0 (bubble inserted); the upstream instruction stays presented.
  - in_valid: out_valid<=1 and the out_* fields load the selected operands and input fields.
  - otherwise: out_valid<=0.
- Latency is 1 cycle from acceptance to out_valid. Throughput is 1 instruction/cycle when there is no hazard and no hold.
- Operands captured at acceptance stay valid during hold, because every older producer was either bypassed or interlocked.
- stall_cnt increments when in_valid & ~in_ready & ~flush. It saturates at all-ones and does not wrap.
- Simultaneous hazard and hold: hold wins, and the outputs keep the valid instruction.
- Simultaneous flush and hold: flush wins.
- A reset asserted mid-stall clears the bubble state and the counter immediately.

Decomposition:
- Shared package holds:
  - XLEN;
  - register-index width 5;
  - constant REG_ZERO = 0;
  - struct id_ex_t bundling pc/op1/op2/imm/rd/we/is_load/ctrl, used by the execute stage as well.
- Natural sub-module: operand_bypass, a combinational per-operand mux with inputs rs, rf_data, MEM info and WB info. It is instantiated twice.

Test Plan:
- RF x5=0x1234, no hazards, in_rs1=5, in_rs2=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_op1=0x1234, out_op2=0.
- wb_we=1, wb_wa=7, wb_wd=0xAAAA while RF x7=0 and in_rs1=7 -> out_op1=0xAAAA. Repeat with mem_wa=7, mem_wd=0xBBBB (non-load) also set -> out_op1=0xBBBB.
- EX holds rd=3 with out_we=1, next instruction uses rs2=3 -> in_ready=0 for 1 cycle, bubble (out_valid=0), stall_cnt=1; then accepted with MEM-forwarded value.
- Load in MEM with rd=9, ID instruction uses rs1=9 -> 1-cycle stall, then captured via WB bypass = load data 0xDEADBEEF.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0, stall_cnt +3. Then flush=1 -> out_valid=0 the next cycle and in_ready=1 during the flush.
- rstn pulsed low mid-hold, asynchronously between edges -> out_valid=0 and stall_cnt=0 immediately, without waiting for clk.
